// File: rtl/online_div_pkg.sv
// ----------------------------------------------------------------------------
// online_div_pkg
// Shared definitions for the radix-2 online divider sequencer:
//   - signed-digit encoding constants (SD_POS / SD_NEG / SD_ZERO)
//   - sequencer state enum (IDLE / RUN / DONE)
//   - sd_decode():     maps any 2-bit digit to a legal value (2'b11 -> 0)
//   - sd_is_illegal(): flags the unused 2'b11 encoding
// ----------------------------------------------------------------------------
package online_div_pkg;

    localparam logic [1:0] SD_POS  = 2'b10;  // +1
    localparam logic [1:0] SD_NEG  = 2'b01;  // -1
    localparam logic [1:0] SD_ZERO = 2'b00;  //  0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The unused code 2'b11 collapses to zero so the datapath never sees it.
    function automatic logic [1:0] sd_decode(input logic [1:0] d);
        case (d)
            SD_POS:  return SD_POS;
            SD_NEG:  return SD_NEG;
            default: return SD_ZERO;
        endcase
    endfunction

    function automatic logic sd_is_illegal(input logic [1:0] d);
        return (d == 2'b11);
    endfunction

endpackage

// File: rtl/sd_digit_shreg.sv
// ----------------------------------------------------------------------------
// sd_digit_shreg
// Dual plus/minus shift register holding a redundant signed-digit vector.
// New digits enter at the LSB, so the first digit shifted in ends up as the
// MSB after WIDTH shifts (most significant digit first).
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   i_clr               synchronous clear of both vectors (wins over shift)
//   i_shift_en          shift one digit in this edge
//   i_d_plus/i_d_minus  plus/minus bit of the incoming digit
//   o_q_plus/o_q_minus  collected vectors
// ----------------------------------------------------------------------------
module sd_digit_shreg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_d_plus,
    input  logic             i_d_minus,
    output logic [WIDTH-1:0] o_q_plus,
    output logic [WIDTH-1:0] o_q_minus
);

    logic [WIDTH-1:0] r_plus;
    logic [WIDTH-1:0] r_minus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plus  <= '0;
            r_minus <= '0;
        end else if (i_clr) begin
            r_plus  <= '0;
            r_minus <= '0;
        end else if (i_shift_en) begin
            r_plus  <= {r_plus[WIDTH-2:0],  i_d_plus};
            r_minus <= {r_minus[WIDTH-2:0], i_d_minus};
        end
    end

    assign o_q_plus  = r_plus;
    assign o_q_minus = r_minus;

endmodule

// File: rtl/online_div_seq_ctrl.sv
// ----------------------------------------------------------------------------
// online_div_seq_ctrl
// Sequencer for the radix-2 online divider datapath. On start it streams
// operand digits from an async-read digit memory into the datapath, enables
// the residual registers, drops quotient digits during the online delay and
// then collects one quotient digit per cycle into plus/minus vectors.
//
// Parameters: UNROLLING (digits per division), ONLINE_DELAY, ADDR_WIDTH.
// Ports:
//   clk, reset               clock, async active-high reset
//   start, abort             request / cancel a division
//   x_digit_in               operand digit read at rd_addr (same cycle)
//   q_value                  quotient digit from the selection logic
//   rd_addr                  operand address (= cnt during RUN)
//   x_value                  operand digit to datapath (combinational)
//   w_clr                    residual clear (combinational, IDLE & start)
//   w_en                     residual update enable
//   busy, done               status; done is a one-cycle pulse
//   q_plus_vec, q_minus_vec  collected quotient, MSD first
//   digit_err                sticky illegal-digit flag, present only when
//                            ONLINE_DIV_DIGIT_CHK_EN is defined
// ----------------------------------------------------------------------------
module online_div_seq_ctrl
    import online_div_pkg::*;
#(
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            x_digit_in,
    input  logic [1:0]            q_value,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]            x_value,
    output logic                  w_clr,
    output logic                  w_en,
    output logic                  busy,
    output logic                  done,
    output logic [UNROLLING-1:0]  q_plus_vec,
    output logic [UNROLLING-1:0]  q_minus_vec
`ifdef ONLINE_DIV_DIGIT_CHK_EN
    ,
    output logic                  digit_err
`endif
);

    // The counter shares the address width; ADDR_WIDTH is required to cover
    // the whole RUN range, so rd_addr is simply the counter.
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(UNROLLING + ONLINE_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_OPND  = ADDR_WIDTH'(UNROLLING);
    localparam logic [ADDR_WIDTH-1:0] CNT_DELAY = ADDR_WIDTH'(ONLINE_DELAY);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;

    logic w_start_acc;   // start accepted in IDLE this cycle
    logic w_q_shift;     // collect q_value at this edge
    logic w_in_opnd;     // cnt still inside the operand length
    logic w_in_quot;     // cnt past the online delay
    logic [1:0] w_q_dec;

    assign w_in_opnd = (r_cnt < CNT_OPND);
    assign w_in_quot = (r_cnt >= CNT_DELAY);
    assign w_q_dec   = sd_decode(q_value);

    // ------------------------------------------------------------------
    // State register and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter only advances while staying in RUN; any other path
            // (entry from IDLE, abort, finish) leaves it at 0.
            if (r_state == ST_RUN && w_state_nxt == ST_RUN)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_q_shift   = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        rd_addr     = '0;
        x_value     = SD_ZERO;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                busy    = 1'b1;
                w_en    = 1'b1;
                rd_addr = r_cnt;
                // Past the operand length the datapath is fed zero digits.
                if (w_in_opnd)
                    x_value = sd_decode(x_digit_in);
                // Abort takes priority over both collection and completion,
                // so the vectors keep only the digits gathered before it.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_q_shift = w_in_quot;
                    if (r_cnt == CNT_LAST)
                        w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Quotient collection
    // ------------------------------------------------------------------
    sd_digit_shreg #(
        .WIDTH (UNROLLING)
    ) u_q_shreg (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_start_acc),
        .i_shift_en (w_q_shift),
        .i_d_plus   (w_q_dec[1]),
        .i_d_minus  (w_q_dec[0]),
        .o_q_plus   (q_plus_vec),
        .o_q_minus  (q_minus_vec)
    );

`ifdef ONLINE_DIV_DIGIT_CHK_EN
    // ------------------------------------------------------------------
    // Sticky illegal-digit detector; only digits that would actually be
    // consumed (operand in range, quotient past the delay) are checked.
    // ------------------------------------------------------------------
    logic r_digit_err;
    logic w_digit_bad;

    assign w_digit_bad = (r_state == ST_RUN) &&
                         ((w_in_opnd && sd_is_illegal(x_digit_in)) ||
                          (w_in_quot && sd_is_illegal(q_value)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_digit_err <= 1'b0;
        else if (w_start_acc)
            r_digit_err <= 1'b0;
        else if (w_digit_bad)
            r_digit_err <= 1'b1;
    end

    assign digit_err = r_digit_err;
`endif

endmodule

// File: tb/tb_online_div_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_online_div_seq_ctrl
// Self-checking bench for online_div_seq_ctrl with UNROLLING=8,
// ONLINE_DELAY=3. The operand memory and quotient source are modelled as
// arrays indexed by rd_addr. Expected quotient vectors are pushed to a
// scoreboard on each accepted start and popped when done pulses.
// ----------------------------------------------------------------------------
module tb_online_div_seq_ctrl;

    localparam int U  = 8;
    localparam int OD = 3;
    localparam int AW = 7;
    localparam int NC = U + OD;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [1:0]    x_digit_in, q_value;
    logic [AW-1:0] rd_addr;
    logic [1:0]    x_value;
    logic          w_clr, w_en, busy, done;
    logic [U-1:0]  q_plus_vec, q_minus_vec;
`ifdef ONLINE_DIV_DIGIT_CHK_EN
    logic          digit_err;
`endif

    logic [1:0] mem  [0:(1<<AW)-1];
    logic [1:0] qmem [0:(1<<AW)-1];
    assign x_digit_in = mem[rd_addr];
    assign q_value    = qmem[rd_addr];

    online_div_seq_ctrl #(
        .UNROLLING(U), .ONLINE_DELAY(OD), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x_digit_in(x_digit_in), .q_value(q_value),
        .rd_addr(rd_addr), .x_value(x_value), .w_clr(w_clr), .w_en(w_en),
        .busy(busy), .done(done),
        .q_plus_vec(q_plus_vec), .q_minus_vec(q_minus_vec)
`ifdef ONLINE_DIV_DIGIT_CHK_EN
        , .digit_err(digit_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [1:0] xdig;   // operand digit returned at every address
        logic [10:0] qpos;  // bit i: plus bit of q_value when cnt = i
        logic [10:0] qneg;  // bit i: minus bit of q_value when cnt = i
        logic [7:0] ep;     // expected q_plus_vec at done
        logic [7:0] em;     // expected q_minus_vec at done
    } vec_t;

    vec_t vt [6];
    logic [15:0] sbq [$];
    logic [15:0] sb_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] tdec(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    // Quotient vectors after collection stopped before cnt = upto.
    function automatic logic [15:0] model_q(input logic [10:0] p, input logic [10:0] n, input int upto);
        logic [7:0] qp = '0;
        logic [7:0] qm = '0;
        for (int i = OD; i < upto; i++) begin
            qp = {qp[6:0], p[i] & ~n[i]};
            qm = {qm[6:0], n[i] & ~p[i]};
        end
        return {qp, qm};
    endfunction

    // Scoreboard: every done pulse must match a pending expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_e = sbq.pop_front();
                chk("q_plus_vec",  32'(q_plus_vec),  32'(sb_e[15:8]));
                chk("q_minus_vec", 32'(q_minus_vec), 32'(sb_e[7:0]));
            end
        end
    end

    task automatic load(input vec_t v);
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]  = v.xdig;
            qmem[i] = (i < NC) ? {v.qpos[i], v.qneg[i]} : 2'b00;
        end
    endtask

    // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // IDLE cycle following DONE.
    task automatic run_vec(input int k, input bit hold);
        load(vt[k]);
        start = 1'b1;
        @(negedge clk);
        chk({vt[k].name, "_wclr"}, 32'(w_clr), 32'd1);
        chk({vt[k].name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({vt[k].name, "_idle_done"}, 32'(done), 32'd0);
        sbq.push_back({vt[k].ep, vt[k].em});
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            chk({vt[k].name, "_busy"},   32'(busy),    32'd1);
            chk({vt[k].name, "_w_en"},   32'(w_en),    32'd1);
            chk({vt[k].name, "_done"},   32'(done),    32'd0);
            chk({vt[k].name, "_rdaddr"}, 32'(rd_addr), 32'(c));
            chk({vt[k].name, "_xval"},   32'(x_value), (c < U) ? 32'(tdec(vt[k].xdig)) : 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({vt[k].name, "_done_pulse"}, 32'(done), 32'd1);
        chk({vt[k].name, "_done_busy"},  32'(busy), 32'd0);
        chk({vt[k].name, "_done_wen"},   32'(w_en), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic abort_run(input int k, input int at);
        logic [15:0] e;
        load(vt[k]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= at; c++) begin
            if (c == at) abort = 1'b1;
            @(negedge clk);
            chk("abort_run_addr", 32'(rd_addr), 32'(c));
            @(posedge clk); #1;
        end
        abort = 1'b0;
        e = model_q(vt[k].qpos, vt[k].qneg, at);
        @(negedge clk);
        chk("abort_busy",   32'(busy),        32'd0);
        chk("abort_done",   32'(done),        32'd0);
        chk("abort_qplus",  32'(q_plus_vec),  32'(e[15:8]));
        chk("abort_qminus", 32'(q_minus_vec), 32'(e[7:0]));
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_idle_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{"spec_vec",   2'b01, 11'b100_0010_1000, 11'b011_1101_0111, 8'b10100001, 8'b01011110};
        vt[1] = '{"all_zero",   2'b10, 11'b000_0000_0000, 11'b000_0000_0000, 8'h00, 8'h00};
        vt[2] = '{"all_pos",    2'b00, 11'b111_1111_1111, 11'b000_0000_0000, 8'hFF, 8'h00};
        vt[3] = '{"all_illeg",  2'b11, 11'b111_1111_1111, 11'b111_1111_1111, 8'h00, 8'h00};
        vt[4] = '{"delay_drop", 2'b01, 11'b000_0000_0111, 11'b111_1111_1000, 8'h00, 8'hFF};
        vt[5] = '{"edges",      2'b10, 11'b000_0000_1000, 11'b100_0000_0000, 8'h80, 8'h01};

        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]  = 2'b00;
            qmem[i] = 2'b00;
        end
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_done",   32'(done),        32'd0);
        chk("rst_wen",    32'(w_en),        32'd0);
        chk("rst_wclr",   32'(w_clr),       32'd0);
        chk("rst_rdaddr", 32'(rd_addr),     32'd0);
        chk("rst_xval",   32'(x_value),     32'd0);
        chk("rst_qplus",  32'(q_plus_vec),  32'd0);
        chk("rst_qminus", 32'(q_minus_vec), 32'd0);
`ifdef ONLINE_DIV_DIGIT_CHK_EN
        chk("rst_digit_err", 32'(digit_err), 32'd0);
`endif
        @(posedge clk); #1;

        // Table-driven runs
        for (int k = 0; k < 6; k++) run_vec(k, 1'b0);

        // Abort mid-run, then a full run; abort on the last count
        abort_run(0, 5);
        run_vec(0, 1'b0);
        abort_run(2, NC - 1);

        // start held high: back-to-back runs with one IDLE cycle between
        run_vec(0, 1'b1);
        run_vec(5, 1'b0);

        // Reset mid-run: outputs drop immediately, no done afterwards
        load(vt[2]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mrst_busy",   32'(busy),        32'd0);
        chk("mrst_wen",    32'(w_en),        32'd0);
        chk("mrst_rdaddr", 32'(rd_addr),     32'd0);
        chk("mrst_xval",   32'(x_value),     32'd0);
        chk("mrst_qplus",  32'(q_plus_vec),  32'd0);
        chk("mrst_qminus", 32'(q_minus_vec), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (NC + 2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mrst_stay_idle", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;

`ifdef ONLINE_DIV_DIGIT_CHK_EN
        // Illegal operand digit at cnt=2
        load(vt[1]);
        mem[2] = 2'b11;
        start = 1'b1;
        sbq.push_back({8'h00, 8'h00});
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            chk("derr_flag", 32'(digit_err), (c > 2) ? 32'd1 : 32'd0);
            if (c == 2) chk("derr_xval", 32'(x_value), 32'd0);
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("derr_sticky", 32'(digit_err), 32'd1);
        mem[2] = 2'b10;
        @(posedge clk); #1;
        run_vec(1, 1'b0);
        chk("derr_cleared", 32'(digit_err), 32'd0);
`endif

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
